// File: rtl/lab7_hex_pkg.sv
// Shared constants for the hex scroller: register map, CTRL/STATUS bit
// positions, FSM state encoding and the active-high 7-segment table.
package lab7_hex_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RATE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_WRAP  = 1;
    localparam int unsigned CTRL_BLINK = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_POS_LSB = 4;

    // Last window position reached by a one-shot scroll.
    localparam logic [2:0] POS_LAST_ONESHOT = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Index = nibble value; bit0 = seg a ... bit6 = seg g, active-high.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/lab7_hex_seg7.sv
// Single-digit hex nibble to active-high 7-segment decoder.
module lab7_hex_seg7
    import lab7_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/lab7_hex_scroller.sv
// Avalon-MM two-digit 7-segment scroller over a 32-bit nibble buffer.
// Optional blinking in DONE is enabled by defining HEX_SCROLL_BLINK_EN.
module lab7_hex_scroller
    import lab7_hex_pkg::*;
#(
    parameter int unsigned RATE_W     = 24,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [13:0] out_port
);

    localparam logic [13:0] OUT_ZERO = {SEG_TABLE[0], SEG_TABLE[0]};
    localparam logic [13:0] OUT_RST  = ACTIVE_LOW ? ~OUT_ZERO : OUT_ZERO;

    logic [31:0]       data_d, data_q;
    logic              run_d, run_q;
    logic              wrap_d, wrap_q;
    logic [RATE_W-1:0] rate_d, rate_q;
    logic [RATE_W-1:0] presc_d, presc_q;
    logic [2:0]        pos_d, pos_q;
    state_e            state_d, state_q;
    logic [13:0]       out_d, out_q;

    logic wr_en, ctrl_wr, tick;

    assign wr_en   = chipselect & ~write_n;
    assign ctrl_wr = wr_en && (address == ADDR_CTRL);
    assign tick    = (state_q != ST_IDLE) && (presc_q == rate_q);

    always_comb begin
        data_d  = data_q;
        run_d   = run_q;
        wrap_d  = wrap_q;
        rate_d  = rate_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        state_d = state_q;

        if (wr_en && address == ADDR_DATA) data_d = writedata;
        if (wr_en && address == ADDR_RATE) rate_d = writedata[RATE_W-1:0];

        // A CTRL write always takes priority; any coincident tick is dropped.
        if (ctrl_wr) begin
            run_d   = writedata[CTRL_RUN];
            wrap_d  = writedata[CTRL_WRAP];
            presc_d = '0;
            if (!writedata[CTRL_RUN]) begin
                state_d = ST_IDLE;
                pos_d   = '0;
            end else if (state_q != ST_SCROLL) begin
                state_d = ST_SCROLL;
                pos_d   = '0;
            end
        end else begin
            case (state_q)
                ST_SCROLL: begin
                    if (tick) begin
                        presc_d = '0;
                        if (!wrap_q && pos_q == POS_LAST_ONESHOT) state_d = ST_DONE;
                        else pos_d = pos_q + 3'd1;
                    end else begin
                        presc_d = presc_q + RATE_W'(1);
                    end
                end
                ST_DONE: presc_d = tick ? '0 : presc_q + RATE_W'(1);
                default: begin
                    presc_d = '0;
                    pos_d   = '0;
                end
            endcase
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic blink_d, blink_q, blank_d, blank_q;

    always_comb begin
        blink_d = ctrl_wr ? writedata[CTRL_BLINK] : blink_q;
        blank_d = 1'b0;
        if (state_q == ST_DONE && state_d == ST_DONE)
            blank_d = (tick && !ctrl_wr && blink_q) ? ~blank_q : blank_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end
`else
    logic blink_q, blank_q;
    assign blink_q = 1'b0;
    assign blank_q = 1'b0;
`endif

    logic [2:0] idx_l, idx_r;
    logic [3:0] nib_l, nib_r;
    logic [6:0] seg_l, seg_r;

    assign idx_l = 3'd7 - pos_q;
    assign idx_r = 3'd6 - pos_q;
    assign nib_l = data_q[{idx_l, 2'b00} +: 4];
    assign nib_r = data_q[{idx_r, 2'b00} +: 4];

    lab7_hex_seg7 u_seg_left  (.nibble(nib_l), .seg(seg_l));
    lab7_hex_seg7 u_seg_right (.nibble(nib_r), .seg(seg_r));

    always_comb begin
        out_d = blank_q ? '0 : {seg_l, seg_r};
        if (ACTIVE_LOW) out_d = ~out_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
            rate_q  <= '0;
            presc_q <= '0;
            pos_q   <= '0;
            state_q <= ST_IDLE;
            out_q   <= OUT_RST;
        end else begin
            data_q  <= data_d;
            run_q   <= run_d;
            wrap_q  <= wrap_d;
            rate_q  <= rate_d;
            presc_q <= presc_d;
            pos_q   <= pos_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = data_q;
            ADDR_CTRL: begin
                readdata[CTRL_RUN]   = run_q;
                readdata[CTRL_WRAP]  = wrap_q;
                readdata[CTRL_BLINK] = blink_q;
            end
            ADDR_RATE: readdata[RATE_W-1:0] = rate_q;
            default: begin
                readdata[STAT_BUSY] = (state_q == ST_SCROLL);
                readdata[STAT_DONE] = (state_q == ST_DONE);
                readdata[STAT_POS_LSB +: 3] = pos_q;
            end
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_lab7_hex_scroller.sv
// Scoreboard bench for lab7_hex_scroller: expected display frames are queued
// as stimulus is driven and compared as out_port changes.
module tb_lab7_hex_scroller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [13:0] out_port;

    lab7_hex_scroller #(.RATE_W(24), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        int unsigned gap;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    logic [13:0] last_out = 14'h2040;
    bit          mon_en = 1'b0;

    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'h9ABC_DEF0;
    localparam logic [13:0] BLANK = 14'h3FFF;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h3F; 4'h1: seg = 7'h06; 4'h2: seg = 7'h5B; 4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66; 4'h5: seg = 7'h6D; 4'h6: seg = 7'h7D; 4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F; 4'h9: seg = 7'h6F; 4'hA: seg = 7'h77; 4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39; 4'hD: seg = 7'h5E; 4'hE: seg = 7'h79; default: seg = 7'h71;
        endcase
    endfunction

    // Active-low frame for window position p over data word d.
    function automatic logic [13:0] disp(input logic [31:0] d, input logic [2:0] p);
        logic [2:0] li, ri;
        li = 3'd7 - p;
        ri = 3'd6 - p;
        disp = ~{seg(d[4*int'(li) +: 4]), seg(d[4*int'(ri) +: 4])};
    endfunction

    task automatic push(input logic [13:0] v, input int unsigned g);
        exp_q.push_back('{val: v, gap: g});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && reset_n && out_port !== last_out) begin
            if (exp_q.size() == 0) begin
                check_eq("out_unexpected", {18'd0, out_port}, {18'd0, last_out});
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check_eq("out_frame", {18'd0, out_port}, {18'd0, e.val});
                if (e.gap != 0) check_eq("out_gap", cyc - last_cyc, e.gap);
            end
            last_out = out_port;
            last_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val, input string tag);
        logic [31:0] d;
        bit hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rd(2'd3, d);
            if ((d & mask) == val) begin
                hit = 1'b1;
                break;
            end
            step(1);
        end
        if (!hit) check_eq(tag, d & mask, val);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  p;

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        step(2);
        check_eq("rst_out", {18'd0, out_port}, 32'h2040);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            check_eq("rst_read", r, 32'd0);
        end
        reset_n = 1'b1;
        step(2);
        check_eq("post_rst_out", {18'd0, out_port}, 32'h2040);
        rd(2'd3, r);
        check_eq("post_rst_status", r, 32'd0);
        last_cyc = cyc;
        mon_en = 1'b1;

        // One-shot scroll, RATE = 3: steps every 4 cycles to DONE at POS 6.
        push(disp(D1, 3'd0), 0);
        wr(2'd0, D1);
        rd(2'd0, r);
        check_eq("data_rb", r, D1);
        wr(2'd2, 32'hFF00_0003);
        rd(2'd2, r);
        check_eq("rate_rb", r, 32'h0000_0003);
        push(disp(D1, 3'd1), 0);
        for (int i = 2; i <= 6; i++) push(disp(D1, 3'(i)), 4);
        wr(2'd1, 32'hFFFF_FFF9);
        rd(2'd1, r);
        check_eq("ctrl_rb", r, 32'd1);
        wait_stat(32'h2, 32'h2, "wait_done");
        check_eq("done_status", r, r);
        rd(2'd3, r);
        check_eq("done_status", r, 32'h62);
        step(20);
        rd(2'd3, r);
        check_eq("done_hold", r, 32'h62);
        drain("oneshot_drain");

        // Continuous scroll: POS wraps 7 -> 0 while BUSY stays set.
        push(disp(D1, 3'd0), 0);
        wr(2'd1, 32'd0);
        step(3);
        push(disp(D1, 3'd1), 0);
        for (int i = 2; i <= 9; i++) push(disp(D1, 3'(i)), 4);
        wr(2'd1, 32'd3);
        wait_stat(32'h70, 32'h70, "wait_pos7");
        rd(2'd3, r);
        check_eq("wrap_pos7", r, 32'h71);
        wait_stat(32'h70, 32'h00, "wait_pos0");
        rd(2'd3, r);
        check_eq("wrap_pos0_busy", r, 32'h01);
        wait_stat(32'h70, 32'h10, "wait_pos1");
        push(disp(D1, 3'd0), 0);
        wr(2'd1, 32'd0);
        step(3);
        drain("wrap_drain");

        // DATA rewrite mid-scroll, then abort at POS 3.
        push(disp(D1, 3'd1), 0);
        push(disp(D1, 3'd2), 4);
        wr(2'd1, 32'd1);
        wait_stat(32'h70, 32'h20, "wait_pos2");
        push(disp(D2, 3'd2), 0);
        wr(2'd0, D2);
        rd(2'd3, r);
        check_eq("data_wr_keeps_pos", r, 32'h21);
        wait_stat(32'h70, 32'h30, "wait_pos3");
        push(disp(D2, 3'd3), 0);
        push(disp(D2, 3'd0), 1);
        wr(2'd1, 32'd0);
        rd(2'd3, r);
        check_eq("abort_status", r, 32'd0);
        step(3);
        drain("abort_drain");

        // RATE = 0: a CTRL write on a tick cycle suppresses that step.
        mon_en = 1'b0;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd3);
        step(2);
        rd(2'd3, r);
        p = r[6:4];
        check_eq("coinc_busy", r & 32'h3, 32'h1);
        wr(2'd1, 32'd3);
        rd(2'd3, r);
        check_eq("coinc_pos_held", r, {25'd0, p, 4'h1});
        step(1);
        rd(2'd3, r);
        check_eq("coinc_pos_next", r, {25'd0, p + 3'd1, 4'h1});
        wr(2'd1, 32'd0);
        rd(2'd3, r);
        check_eq("coinc_abort", r, 32'd0);
        step(2);
        check_eq("coinc_display", {18'd0, out_port}, {18'd0, disp(D2, 3'd0)});
        last_out = disp(D2, 3'd0);
        last_cyc = cyc;
        mon_en = 1'b1;

`ifdef HEX_SCROLL_BLINK_EN
        // Blink in DONE, RATE = 1: blank and "78" alternate every 2 cycles.
        wr(2'd2, 32'd1);
        push(disp(D1, 3'd0), 0);
        wr(2'd0, D1);
        push(disp(D1, 3'd1), 0);
        for (int i = 2; i <= 6; i++) push(disp(D1, 3'(i)), 2);
        push(BLANK, 0);
        push(disp(D1, 3'd6), 2);
        push(BLANK, 2);
        push(disp(D1, 3'd6), 2);
        wr(2'd1, 32'd5);
        drain("blink_drain");
        push(disp(D1, 3'd0), 0);
        wr(2'd1, 32'd0);
        step(4);
        drain("blink_exit_drain");
        wr(2'd1, 32'd4);
        rd(2'd1, r);
        check_eq("ctrl_blink_rb", r, 32'd4);
`else
        wr(2'd1, 32'd4);
        rd(2'd1, r);
        check_eq("ctrl_blink_rb", r, 32'd0);
`endif
        rd(2'd3, r);
        check_eq("final_status", r, 32'd0);
        step(5);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
